// File: rtl/toeplitz_ctrl_if.sv
// Handshake bundle between the Toeplitz hash sequencer and its seed ROM, shift, FIFO and summing stages.
// stall_cycles exists only when TOEPLITZ_CTRL_PERF_EN is defined.
interface toeplitz_ctrl_if;
    logic        start;
    logic [15:0] block_cnt;
    logic        rom_en;
    logic [7:0]  rom_addr;
    logic        shift_en;
    logic        shift_ack;
    logic        coeff_empty;
    logic        result_full;
    logic        sum_en;
    logic        result_wr;
    logic        busy;
    logic        done;
    logic [15:0] blocks_done;
`ifdef TOEPLITZ_CTRL_PERF_EN
    logic [31:0] stall_cycles;
`endif

    modport master (
        output start, block_cnt, shift_ack, coeff_empty, result_full, result_wr,
`ifdef TOEPLITZ_CTRL_PERF_EN
        input  stall_cycles,
`endif
        input  rom_en, rom_addr, shift_en, sum_en, busy, done, blocks_done
    );

    modport slave (
        input  start, block_cnt, shift_ack, coeff_empty, result_full, result_wr,
`ifdef TOEPLITZ_CTRL_PERF_EN
        output stall_cycles,
`endif
        output rom_en, rom_addr, shift_en, sum_en, busy, done, blocks_done
    );
endinterface

// File: rtl/toeplitz_ctrl.sv
// Job sequencer for a Toeplitz hash: loads the seed once, then streams ROWS coefficient beats per block.
// Optional stall counter enabled by defining TOEPLITZ_CTRL_PERF_EN.
module toeplitz_ctrl #(
    parameter int SEED_WORDS = 224,
    parameter int ROWS       = 96
) (
    input  logic           clk_in,
    input  logic           rst,
    toeplitz_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        LTAIL  = 3'd2,
        SHIFT  = 3'd3,
        HASH   = 3'd4,
        WAITWR = 3'd5,
        FIN    = 3'd6
    } state_e;

    localparam logic [7:0] LAST_ADDR = 8'(SEED_WORDS - 1);
    localparam logic [6:0] LAST_BEAT = 7'(ROWS - 1);

    state_e      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [6:0]  beat_q, beat_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] blk_q, blk_d;
    logic        done_q, done_d;
    logic        sum_en_s;
    logic [15:0] blk_inc_s;

    assign sum_en_s  = (state_q == HASH) && !bus.coeff_empty && !bus.result_full;
    assign blk_inc_s = blk_q + 16'd1;

    // State and datapath registers.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 8'd0;
            beat_q  <= 7'd0;
            cnt_q   <= 16'd0;
            blk_q   <= 16'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cnt_d  = bus.block_cnt;
                    blk_d  = 16'd0;
                    addr_d = 8'd0;
                    beat_d = 7'd0;
                    if (bus.block_cnt == 16'd0) begin
                        state_d = FIN;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d  = 8'd0;
                    state_d = LTAIL;
                end else begin
                    addr_d = addr_q + 8'd1;
                end
            end
            // Extra cycle lets the last ROM word arrive before the shift stage latches the seed.
            LTAIL: state_d = SHIFT;
            SHIFT: begin
                if (bus.shift_ack) begin
                    state_d = HASH;
                end else begin
                    state_d = SHIFT;
                end
            end
            HASH: begin
                if (sum_en_s) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = 7'd0;
                        state_d = WAITWR;
                    end else begin
                        beat_d = beat_q + 7'd1;
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            // Next block reuses the seed already held by the shift stage.
            WAITWR: begin
                if (bus.result_wr) begin
                    blk_d = blk_inc_s;
                    if (blk_inc_s < cnt_q) begin
                        state_d = HASH;
                    end else begin
                        state_d = FIN;
                    end
                end else begin
                    state_d = WAITWR;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rom_en      = (state_q == LOAD);
    assign bus.rom_addr    = addr_q;
    assign bus.shift_en    = (state_q == SHIFT);
    assign bus.sum_en      = sum_en_s;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.blocks_done = blk_q;

`ifdef TOEPLITZ_CTRL_PERF_EN
    logic [31:0] stall_q, stall_d;

    // Stall counter next value: cleared per job, saturating.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == IDLE) && bus.start) begin
            stall_d = 32'd0;
        end else if ((state_q == HASH) && !sum_en_s && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            stall_q <= 32'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign bus.stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_toeplitz_ctrl.sv
// Directed, table-driven bench for toeplitz_ctrl with a cycle-level protocol model.
// Define TOEPLITZ_CTRL_PERF_EN to also check stall_cycles.
module tb_toeplitz_ctrl;
    logic clk_in = 1'b0;
    logic rst    = 1'b1;

    toeplitz_ctrl_if bus ();

    toeplitz_ctrl #(.SEED_WORDS(224), .ROWS(96)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int cnt;
        int ack_dly;
        int wr_dly;
        int e_lo;
        int e_hi;
        int f_lo;
        int f_hi;
        bit noise;
        bit restart;
        int exp_reads;
        int exp_beats;
        int exp_shifts;
        int exp_blocks;
        int exp_stalls;
    } vec_t;

    vec_t vecs [7];
    int checks = 0;
    int errors = 0;

    int r_reads, r_beats, r_shifts, r_dones, r_done_cyc;
    int r_sum_bad, r_addr_bad, r_bd_bad, r_busy_bad, r_timeout, r_done_busy;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic run_job(input vec_t v);
        int  sh_seen = 0;
        int  hc = 0;
        int  blk_beats = 0;
        int  w = 0;
        int  model_blk = 0;
        bit  in_hash = 1'b0;
        bit  waiting = 1'b0;
        bit  hs_ack;
        bit  exp_sum;
        bit  finished = 1'b0;
        r_reads = 0; r_beats = 0; r_shifts = 0; r_dones = 0; r_done_cyc = -1;
        r_sum_bad = 0; r_addr_bad = 0; r_bd_bad = 0; r_busy_bad = 0; r_timeout = 0; r_done_busy = 0;

        @(posedge clk_in); #1;
        bus.start     = 1'b1;
        bus.block_cnt = 16'(v.cnt);
        @(posedge clk_in); #1;
        bus.start = 1'b0;

        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            hs_ack           = bus.shift_en && (sh_seen == v.ack_dly);
            bus.shift_ack    = hs_ack || (v.noise && bus.rom_en);
            bus.coeff_empty  = in_hash && (hc >= v.e_lo) && (hc <= v.e_hi);
            bus.result_full  = in_hash && (hc >= v.f_lo) && (hc <= v.f_hi);
            bus.result_wr    = (waiting && (w == v.wr_dly)) || (v.noise && in_hash && (hc == 5));
            bus.start        = v.restart && in_hash && (hc == 40);
            bus.block_cnt    = bus.start ? 16'd5 : 16'(v.cnt);
            @(negedge clk_in);
            exp_sum = in_hash && !bus.coeff_empty && !bus.result_full;
            if (bus.sum_en !== exp_sum) r_sum_bad++;
            if (bus.sum_en) r_beats++;
            if (bus.rom_en) begin
                if (int'(bus.rom_addr) != r_reads) r_addr_bad++;
                r_reads++;
            end
            if (bus.shift_en) begin
                sh_seen++;
                r_shifts++;
            end
            if (int'(bus.blocks_done) != model_blk) r_bd_bad++;
            if ((in_hash || waiting) && !bus.busy) r_busy_bad++;
            if (bus.done) begin
                r_dones++;
                r_done_cyc  = cyc;
                r_done_busy = int'(bus.busy);
                finished    = 1'b1;
            end
            if (in_hash) begin
                if (exp_sum) begin
                    blk_beats++;
                    if (blk_beats == 96) begin
                        blk_beats = 0;
                        in_hash   = 1'b0;
                        waiting   = 1'b1;
                        w         = 0;
                    end
                end
                hc++;
            end else if (waiting) begin
                if (w == v.wr_dly) begin
                    waiting = 1'b0;
                    model_blk++;
                    if (model_blk < v.cnt) in_hash = 1'b1;
                end else begin
                    w++;
                end
            end
            if (hs_ack) in_hash = 1'b1;
            @(posedge clk_in); #1;
        end
        bus.start       = 1'b0;
        bus.shift_ack   = 1'b0;
        bus.coeff_empty = 1'b0;
        bus.result_full = 1'b0;
        bus.result_wr   = 1'b0;
        if (!finished) r_timeout = 1;
    endtask

    initial begin
        bus.start = 1'b0; bus.block_cnt = 16'd0; bus.shift_ack = 1'b0;
        bus.coeff_empty = 1'b0; bus.result_full = 1'b0; bus.result_wr = 1'b0;

        //          cnt ack wr  e_lo e_hi f_lo f_hi noise rst  reads beats shifts blks stalls
        vecs[0] = '{2,  3,  0,  -1,  -2,  -1,  -2,  1'b0, 1'b0, 224, 192,  4,     2,   0};
        vecs[1] = '{0,  0,  0,  -1,  -2,  -1,  -2,  1'b0, 1'b0, 0,   0,    0,     0,   0};
        vecs[2] = '{1,  0,  0,  10,  19,  50,  54,  1'b0, 1'b0, 224, 96,   1,     1,   15};
        vecs[3] = '{1,  1,  2,  30,  34,  32,  36,  1'b0, 1'b1, 224, 96,   2,     1,   7};
        vecs[4] = '{2,  2,  20, -1,  -2,  -1,  -2,  1'b1, 1'b0, 224, 192,  3,     2,   0};
        vecs[5] = '{3,  0,  1,  -1,  -2,  -1,  -2,  1'b0, 1'b0, 224, 288,  1,     3,   0};
        vecs[6] = '{1,  0,  0,  -1,  -2,  -1,  -2,  1'b0, 1'b0, 224, 96,   1,     1,   0};

        repeat (3) @(posedge clk_in);
        #1;
        check("reset_rom_en", bus.rom_en, 0);
        check("reset_rom_addr", bus.rom_addr, 0);
        check("reset_shift_en", bus.shift_en, 0);
        check("reset_sum_en", bus.sum_en, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_blocks_done", bus.blocks_done, 0);
        @(negedge clk_in);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i]);
            check($sformatf("v%0d_timeout", i), r_timeout, 0);
            check($sformatf("v%0d_rom_reads", i), r_reads, vecs[i].exp_reads);
            check($sformatf("v%0d_rom_addr_seq", i), r_addr_bad, 0);
            check($sformatf("v%0d_shift_cycles", i), r_shifts, vecs[i].exp_shifts);
            check($sformatf("v%0d_sum_beats", i), r_beats, vecs[i].exp_beats);
            check($sformatf("v%0d_sum_en_cycles", i), r_sum_bad, 0);
            check($sformatf("v%0d_blocks_done_track", i), r_bd_bad, 0);
            check($sformatf("v%0d_busy", i), r_busy_bad, 0);
            check($sformatf("v%0d_done_pulses", i), r_dones, 1);
            check($sformatf("v%0d_busy_at_done", i), r_done_busy, 0);
            repeat (3) @(posedge clk_in);
            #1;
            check($sformatf("v%0d_done_cleared", i), bus.done, 0);
            check($sformatf("v%0d_blocks_done_hold", i), bus.blocks_done, vecs[i].exp_blocks);
`ifdef TOEPLITZ_CTRL_PERF_EN
            check($sformatf("v%0d_stall_cycles", i), bus.stall_cycles, vecs[i].exp_stalls);
`endif
            if (vecs[i].cnt == 0) check("zero_done_latency", r_done_cyc, 1);
        end

        // Reset in the middle of the seed load abandons the job.
        begin
            int waited = 0;
            int bad = 0;
            @(posedge clk_in); #1;
            bus.start = 1'b1; bus.block_cnt = 16'd1;
            @(posedge clk_in); #1;
            bus.start = 1'b0;
            while (!(bus.rom_en && bus.rom_addr == 8'd100) && waited < 500) begin
                @(posedge clk_in); #1;
                waited++;
            end
            check("rst_reached_addr100", int'(waited < 500), 1);
            #2;
            rst = 1'b1;
            #1;
            check("rst_mid_rom_en", bus.rom_en, 0);
            check("rst_mid_rom_addr", bus.rom_addr, 0);
            check("rst_mid_busy", bus.busy, 0);
            check("rst_mid_done", bus.done, 0);
            @(negedge clk_in);
            rst = 1'b0;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk_in);
                if (bus.done || bus.busy || bus.rom_en) bad++;
            end
            check("rst_no_done_after", bad, 0);
            run_job(vecs[6]);
            check("rst_restart_timeout", r_timeout, 0);
            check("rst_restart_reads", r_reads, vecs[6].exp_reads);
            check("rst_restart_addr_seq", r_addr_bad, 0);
            check("rst_restart_beats", r_beats, vecs[6].exp_beats);
            check("rst_restart_done", r_dones, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/toeplitz_ctrl.md
TOEPLITZ_CTRL -- requirements
Module: toeplitz_ctrl

Interface
REQ-001 SHALL have parameter SEED_WORDS, default 224, meaning 32-bit ROM words per 7168-bit seed.
REQ-002 SHALL have parameter ROWS, default 96, meaning coefficient beats per block (3072/32).
REQ-003 SHALL have port clk_in  in  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  in  1  one-cycle request to run a job.
REQ-006 SHALL have port block_cnt  in  16  blocks to hash in the job, sampled at accepted start.
REQ-007 SHALL have port rom_en  out  1  seed ROM read enable.
REQ-008 SHALL have port rom_addr  out  8  seed ROM word address.
REQ-009 SHALL have port shift_en  out  1  request to the shift stage to latch the seed.
REQ-010 SHALL have port shift_ack  in  1  shift stage acknowledge.
REQ-011 SHALL have port coeff_empty  in  1  coefficient FIFO empty.
REQ-012 SHALL have port result_full  in  1  result FIFO full.
REQ-013 SHALL have port sum_en  out  1  one qualified coefficient beat to the summing stage.
REQ-014 SHALL have port result_wr  in  1  summing stage wrote a block result.
REQ-015 SHALL have ports busy out 1 job active; done out 1 one-cycle completion pulse; blocks_done out 16 results written this job.

Function
REQ-016 SHALL implement states IDLE, LOAD, LTAIL, SHIFT, HASH, WAITWR, FIN.
REQ-017 IDLE: start=1 SHALL latch block_cnt, clear blocks_done, go LOAD, or go FIN if block_cnt==0; start outside IDLE SHALL be ignored.
REQ-018 LOAD: rom_en=1, rom_addr SHALL step 0..SEED_WORDS-1 one per cycle, then go LTAIL for exactly one cycle (ROM read latency 1).
REQ-019 SHIFT: shift_en SHALL be held at 1 until the cycle shift_ack=1, then deassert next cycle and go HASH; shift_ack outside SHIFT SHALL be ignored.
REQ-020 HASH: sum_en SHALL be 1 exactly in cycles where coeff_empty=0 and result_full=0; a 7-bit beat counter SHALL count asserted beats, and after beat ROWS go WAITWR.
REQ-021 WAITWR: on result_wr=1 blocks_done SHALL increment; go HASH if blocks_done+1 < latched count, else FIN; result_wr in any other state SHALL be ignored.
REQ-022 Seed SHALL be loaded once per job, not per block.
REQ-023 FIN: done=1 for one cycle, then IDLE; busy SHALL be 1 in every state except IDLE.
REQ-024 blocks_done SHALL hold its final value in IDLE until the next accepted start.
REQ-025 coeff_empty and result_full asserting together SHALL stall HASH with no beat lost or duplicated.

Reset
REQ-026 rst=1 SHALL immediately force IDLE; rom_en, rom_addr, shift_en, sum_en, busy, done, blocks_done, beat counter SHALL be 0.
REQ-027 Reset mid-job SHALL abandon the job; no done pulse SHALL be produced for it.

Configuration
REQ-028 With TOEPLITZ_CTRL_PERF_EN defined, output stall_cycles out 32 SHALL count HASH cycles with sum_en=0, cleared at accepted start and reset, saturating at all-ones; without it the port and counter SHALL not exist and behaviour SHALL be otherwise identical.

Verification
REQ-029 block_cnt=2, FIFOs never stall, shift_ack 3 cycles after shift_en -> 224 ROM reads addr 0..223, 192 sum_en beats, blocks_done=2, one done pulse.
REQ-030 block_cnt=0 -> no rom_en, no shift_en, done 2 cycles after start, blocks_done=0.
REQ-031 block_cnt=1, coeff_empty=1 on beats 10-19, result_full=1 on beats 50-54 -> exactly 96 sum_en beats; PERF_EN build stall_cycles=15.
REQ-032 start pulsed again during HASH -> ignored, block_cnt change has no effect.
REQ-033 rst asserted mid-LOAD at addr 100 -> outputs 0 same cycle, IDLE, no done; subsequent start restarts at addr 0.
REQ-034 result_wr delayed 20 cycles in WAITWR -> sum_en stays 0 throughout, blocks_done increments on the result_wr cycle.
